alarm_scheduler: RTL and testbench
==================================

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameters (name, default, meaning): SNOOZE_MIN, 5, minutes per snooze; MAX_SNOOZE, 3, snoozes allowed per ring event; RING_TIMEOUT, 2, minutes of unanswered ring before auto-snooze.
REQ-002 clk  in  1  single system clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 enable  in  1  alarm subsystem on (SPDT4); low forces IDLE.
REQ-005 current  in  16  current time, BCD HHMM.
REQ-006 minute_tick  in  1  one-cycle pulse when current advances one minute.
REQ-007 cfg_we  in  1  write strobe for one alarm slot.
REQ-008 cfg_slot  in  2  slot index 0..3 written.
REQ-009 cfg_time  in  16  slot alarm time, BCD HHMM.
REQ-010 cfg_en  in  1  slot enable written with cfg_time.
REQ-011 push_m  in  1  dismiss/start-game request, one-cycle debounced pulse.
REQ-012 push_s  in  1  snooze request, one-cycle debounced pulse.
REQ-013 game_done  in  1  minigame success pulse.
REQ-014 game_start  out  1  one-cycle pulse launching the minigame.
REQ-015 ringing  out  1  high while in RING.
REQ-016 ring_slot  out  2  slot currently being serviced.
REQ-017 state  out  3  current FSM state code.
REQ-018 snooze_left  out  4  minutes remaining in SNOOZE, else 0.
REQ-019 pending  out  4  per-slot latched, unserviced alarm hits.

Function
REQ-020 FSM states SHALL be IDLE=000, ARMED=001, RING=010, GAME=011, SNOOZE=100.
REQ-021 Slot i SHALL latch pending[i] on the first cycle where slot enabled and current==time[i] (rising edge of match); a held match SHALL NOT re-latch.
REQ-022 Match detection and pending latching SHALL run in every state except IDLE; an already-set pending bit SHALL stay set.
REQ-023 ARMED with pending!=0 SHALL go to RING next cycle, ring_slot=lowest set index, that bit cleared, snooze count cleared, timeout counter cleared.
REQ-024 RING: push_m -> GAME with game_start high exactly the transition cycle+1 (one-cycle pulse); push_m and push_s together -> push_m wins.
REQ-025 RING: push_s with snooze count<MAX_SNOOZE -> SNOOZE, snooze_left=SNOOZE_MIN, count+1; at count==MAX_SNOOZE push_s ignored.
REQ-026 RING: RING_TIMEOUT minute_ticks without a press -> SNOOZE as per REQ-025, or stay in RING if count==MAX_SNOOZE.
REQ-027 SNOOZE: each minute_tick decrements snooze_left; tick with snooze_left==1 -> RING, same ring_slot, timeout counter cleared.
REQ-028 SNOOZE: push_m -> ARMED (ring event cancelled, no game).
REQ-029 GAME: game_done -> ARMED; push_m/push_s ignored; no timeout.
REQ-030 enable low in any state -> IDLE next cycle, pending, counters, snooze_left cleared; enable high in IDLE -> ARMED.
REQ-031 cfg_we SHALL update slot next cycle in any state; rewriting the serviced slot SHALL NOT abort RING/GAME/SNOOZE; match-edge history for the written slot cleared.

Reset
REQ-032 Reset low SHALL immediately force state=IDLE, game_start=0, ringing=0, ring_slot=0, snooze_left=0, pending=0, all slots disabled with time 0000.
REQ-033 Reset deassertion mid-operation SHALL resume from IDLE; no game_start is generated by reset.

Structure
REQ-034 State codes and default parameter values SHALL live in shared package service4_pkg.
REQ-035 Slot registers plus per-slot match-edge detection SHALL be sub-module alarm_slot_bank (4 slots, outputs hit[3:0]); FSM and counters stay in alarm_scheduler.

Verification
REQ-036 Slot0=0700 en, enable=1, current 0659->0700 -> pending[0]=1 one cycle later, RING next, ring_slot=0, held 0700 never re-latches.
REQ-037 Slots1,2 both =0815 hit same cycle -> RING slot1; push_m -> game_start one pulse; game_done -> ARMED -> RING slot2.
REQ-038 RING, push_s -> SNOOZE snooze_left=5; five minute_ticks -> 4,3,2,1 then RING same slot.
REQ-039 Three snoozes taken, fourth push_s ignored; two ticks without press -> remains RING; push_m and push_s same cycle -> GAME.
REQ-040 enable dropped during SNOOZE with pending=0100 -> IDLE, pending=0, snooze_left=0; reset asserted in GAME -> all outputs to reset values immediately.

Source files
------------

// File: rtl/service4_pkg.sv
// Shared types, sizes and default timing parameters for the alarm scheduler.
// Helper functions map a pending vector to the slot that is serviced next.
package service4_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned TIME_W    = 16;
  localparam int unsigned CNT_W     = 4;

  localparam int unsigned SNOOZE_MIN_DEF   = 5;
  localparam int unsigned MAX_SNOOZE_DEF   = 3;
  localparam int unsigned RING_TIMEOUT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ARMED  = 3'b001,
    ST_RING   = 3'b010,
    ST_GAME   = 3'b011,
    ST_SNOOZE = 3'b100
  } state_e;

  typedef struct packed {
    logic              en;
    logic [TIME_W-1:0] alarm_time;
  } slot_cfg_t;

  // Lowest-index set bit wins when several slots are pending.
  function automatic logic [SLOT_W-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
    lowest_set = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = SLOT_W'(i);
    end
  endfunction

  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [SLOT_W-1:0] s);
    slot_mask = NUM_SLOTS'(1) << s;
  endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// Four alarm slot registers with per-slot rising-edge match detection.
// hit[i] pulses on the first cycle slot i matches the current time.
module alarm_slot_bank
  import service4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 detect_en,
  input  logic [TIME_W-1:0]    current,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic [TIME_W-1:0]    cfg_time,
  input  logic                 cfg_en,
  output logic [NUM_SLOTS-1:0] hit
);

  slot_cfg_t            slot_q [NUM_SLOTS];
  slot_cfg_t            slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] match_c;
  logic [NUM_SLOTS-1:0] match_q;
  logic [NUM_SLOTS-1:0] match_d;

  // A write clears the slot's match history so a new time equal to now still fires.
  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      slot_d[i]  = slot_q[i];
      match_c[i] = slot_q[i].en && (slot_q[i].alarm_time == current);
      match_d[i] = match_c[i];
      if (cfg_we && (cfg_slot == SLOT_W'(i))) begin
        slot_d[i].en         = cfg_en;
        slot_d[i].alarm_time = cfg_time;
        match_d[i]           = 1'b0;
      end
    end
  end

  assign hit = detect_en ? (match_c & ~match_q) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_q[i] <= '0;
      end
      match_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_q[i] <= slot_d[i];
      end
      match_q <= match_d;
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm ring/snooze/minigame controller servicing four alarm slots.
// Latches slot hits into pending and rings them one at a time, lowest slot first.
module alarm_scheduler
  import service4_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN   = SNOOZE_MIN_DEF,
  parameter int unsigned MAX_SNOOZE   = MAX_SNOOZE_DEF,
  parameter int unsigned RING_TIMEOUT = RING_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [TIME_W-1:0]    current,
  input  logic                 minute_tick,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic [TIME_W-1:0]    cfg_time,
  input  logic                 cfg_en,
  input  logic                 push_m,
  input  logic                 push_s,
  input  logic                 game_done,
  output logic                 game_start,
  output logic                 ringing,
  output logic [SLOT_W-1:0]    ring_slot,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     snooze_left,
  output logic [NUM_SLOTS-1:0] pending
);

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [SLOT_W-1:0]    ring_slot_q, ring_slot_d;
  logic [CNT_W-1:0]     snooze_left_q, snooze_left_d;
  logic [CNT_W-1:0]     snooze_cnt_q, snooze_cnt_d;
  logic [CNT_W-1:0]     timeout_q, timeout_d;
  logic                 game_start_q, game_start_d;
  logic                 ringing_q, ringing_d;
  logic                 can_snooze_c;
  logic                 timeout_hit_c;
  logic [SLOT_W-1:0]    next_slot_c;

  alarm_slot_bank u_slot_bank (
    .clk       (clk),
    .reset     (reset),
    .detect_en (state_q != ST_IDLE),
    .current   (current),
    .cfg_we    (cfg_we),
    .cfg_slot  (cfg_slot),
    .cfg_time  (cfg_time),
    .cfg_en    (cfg_en),
    .hit       (hit)
  );

  assign can_snooze_c  = snooze_cnt_q < CNT_W'(MAX_SNOOZE);
  assign timeout_hit_c = minute_tick && (timeout_q == CNT_W'(RING_TIMEOUT - 1));
  assign next_slot_c   = lowest_set(pending_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: disable overrides everything; in RING a dismiss beats a snooze.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_ARMED;
        ST_ARMED:  if (pending_q != '0) state_d = ST_RING;
        ST_RING: begin
          if (push_m)                                       state_d = ST_GAME;
          else if ((push_s || timeout_hit_c) && can_snooze_c) state_d = ST_SNOOZE;
        end
        ST_SNOOZE: begin
          if (push_m)                                              state_d = ST_ARMED;
          else if (minute_tick && (snooze_left_q == CNT_W'(1)))   state_d = ST_RING;
        end
        ST_GAME:   if (game_done) state_d = ST_ARMED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and counters, keyed on the transition being taken.
  always_comb begin
    pending_d     = pending_q | hit;
    ring_slot_d   = ring_slot_q;
    snooze_left_d = snooze_left_q;
    snooze_cnt_d  = snooze_cnt_q;
    timeout_d     = timeout_q;
    game_start_d  = 1'b0;
    if (state_d == ST_IDLE) begin
      pending_d     = '0;
      snooze_left_d = '0;
      snooze_cnt_d  = '0;
      timeout_d     = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (state_d == ST_RING) begin
            ring_slot_d  = next_slot_c;
            pending_d    = (pending_q | hit) & ~slot_mask(next_slot_c);
            snooze_cnt_d = '0;
            timeout_d    = '0;
          end
        end
        ST_RING: begin
          case (state_d)
            ST_GAME: begin
              game_start_d = 1'b1;
              timeout_d    = '0;
            end
            ST_SNOOZE: begin
              snooze_left_d = CNT_W'(SNOOZE_MIN);
              snooze_cnt_d  = snooze_cnt_q + CNT_W'(1);
              timeout_d     = '0;
            end
            default: begin
              if (minute_tick) timeout_d = timeout_hit_c ? '0 : timeout_q + CNT_W'(1);
            end
          endcase
        end
        ST_SNOOZE: begin
          if (state_d != ST_SNOOZE) begin
            snooze_left_d = '0;
            timeout_d     = '0;
          end else if (minute_tick) begin
            snooze_left_d = snooze_left_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ringing_d = (state_d == ST_RING);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= '0;
      ring_slot_q   <= '0;
      snooze_left_q <= '0;
      snooze_cnt_q  <= '0;
      timeout_q     <= '0;
      game_start_q  <= 1'b0;
      ringing_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      ring_slot_q   <= ring_slot_d;
      snooze_left_q <= snooze_left_d;
      snooze_cnt_q  <= snooze_cnt_d;
      timeout_q     <= timeout_d;
      game_start_q  <= game_start_d;
      ringing_q     <= ringing_d;
    end
  end

  assign state       = state_q;
  assign pending     = pending_q;
  assign ring_slot   = ring_slot_q;
  assign snooze_left = snooze_left_q;
  assign game_start  = game_start_q;
  assign ringing     = ringing_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: each driven cycle queues the expected
// outputs, and a monitor compares them just after the following rising edge.
module tb_alarm_scheduler;
  import service4_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] current;
  logic        minute_tick;
  logic        cfg_we;
  logic [1:0]  cfg_slot;
  logic [15:0] cfg_time;
  logic        cfg_en;
  logic        push_m;
  logic        push_s;
  logic        game_done;
  logic        game_start;
  logic        ringing;
  logic [1:0]  ring_slot;
  logic [2:0]  state;
  logic [3:0]  snooze_left;
  logic [3:0]  pending;

  typedef struct packed {
    logic [15:0] id;
    logic [2:0]  st;
    logic [1:0]  rs;
    logic [3:0]  sl;
    logic [3:0]  pd;
    logic        ring;
    logic        gs;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_err    = 0;
  int   step_no  = 0;

  alarm_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .current     (current),
    .minute_tick (minute_tick),
    .cfg_we      (cfg_we),
    .cfg_slot    (cfg_slot),
    .cfg_time    (cfg_time),
    .cfg_en      (cfg_en),
    .push_m      (push_m),
    .push_s      (push_s),
    .game_done   (game_done),
    .game_start  (game_start),
    .ringing     (ringing),
    .ring_slot   (ring_slot),
    .state       (state),
    .snooze_left (snooze_left),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".state"},       32'(state),       32'(0));
    chk({tag, ".ringing"},     32'(ringing),     32'(0));
    chk({tag, ".game_start"},  32'(game_start),  32'(0));
    chk({tag, ".ring_slot"},   32'(ring_slot),   32'(0));
    chk({tag, ".snooze_left"}, 32'(snooze_left), 32'(0));
    chk({tag, ".pending"},     32'(pending),     32'(0));
  endtask

  // Queue expected outputs for the coming edge, then drop one-cycle pulses.
  task automatic step(input logic [2:0] st, input logic [1:0] rs, input logic [3:0] sl,
                      input logic [3:0] pd, input logic gs);
    exp_t e;
    step_no++;
    e.id   = 16'(step_no);
    e.st   = st;
    e.rs   = rs;
    e.sl   = sl;
    e.pd   = pd;
    e.ring = (st == ST_RING);
    e.gs   = gs;
    exp_q.push_back(e);
    @(negedge clk);
    push_m      = 1'b0;
    push_s      = 1'b0;
    minute_tick = 1'b0;
    game_done   = 1'b0;
    cfg_we      = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] s, input logic [15:0] t, input logic en);
    cfg_we   = 1'b1;
    cfg_slot = s;
    cfg_time = t;
    cfg_en   = en;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      chk($sformatf("state#%0d", e_mon.id),       32'(state),       32'(e_mon.st));
      chk($sformatf("ring_slot#%0d", e_mon.id),   32'(ring_slot),   32'(e_mon.rs));
      chk($sformatf("snooze_left#%0d", e_mon.id), 32'(snooze_left), 32'(e_mon.sl));
      chk($sformatf("pending#%0d", e_mon.id),     32'(pending),     32'(e_mon.pd));
      chk($sformatf("ringing#%0d", e_mon.id),     32'(ringing),     32'(e_mon.ring));
      chk($sformatf("game_start#%0d", e_mon.id),  32'(game_start),  32'(e_mon.gs));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    current     = 16'h0659;
    minute_tick = 1'b0;
    cfg_we      = 1'b0;
    cfg_slot    = 2'd0;
    cfg_time    = 16'h0000;
    cfg_en      = 1'b0;
    push_m      = 1'b0;
    push_s      = 1'b0;
    game_done   = 1'b0;
    #2;
    check_reset("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Configure slots while disabled.
    cfg(2'd0, 16'h0700, 1'b1); step(ST_IDLE, 2'd0, 4'd0, 4'b0000, 1'b0);
    cfg(2'd1, 16'h0815, 1'b1); step(ST_IDLE, 2'd0, 4'd0, 4'b0000, 1'b0);
    cfg(2'd2, 16'h0815, 1'b1); step(ST_IDLE, 2'd0, 4'd0, 4'b0000, 1'b0);
    enable = 1'b1;             step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);
    step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);

    // Slot0 hit at 0700, ring, held match never re-latches.
    current = 16'h0700; step(ST_ARMED, 2'd0, 4'd0, 4'b0001, 1'b0);
    step(ST_RING, 2'd0, 4'd0, 4'b0000, 1'b0);
    repeat (2) step(ST_RING, 2'd0, 4'd0, 4'b0000, 1'b0);
    push_m = 1'b1; step(ST_GAME, 2'd0, 4'd0, 4'b0000, 1'b1);
    step(ST_GAME, 2'd0, 4'd0, 4'b0000, 1'b0);
    push_m = 1'b1; step(ST_GAME, 2'd0, 4'd0, 4'b0000, 1'b0);
    push_s = 1'b1; step(ST_GAME, 2'd0, 4'd0, 4'b0000, 1'b0);
    repeat (3) begin
      minute_tick = 1'b1; step(ST_GAME, 2'd0, 4'd0, 4'b0000, 1'b0);
    end
    game_done = 1'b1; step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);

    // Slots 1 and 2 hit together: slot1 first, then slot2.
    current = 16'h0815; step(ST_ARMED, 2'd0, 4'd0, 4'b0110, 1'b0);
    step(ST_RING, 2'd1, 4'd0, 4'b0100, 1'b0);
    push_m = 1'b1;    step(ST_GAME, 2'd1, 4'd0, 4'b0100, 1'b1);
    game_done = 1'b1; step(ST_ARMED, 2'd1, 4'd0, 4'b0100, 1'b0);
    step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);

    // Snooze #1 by push_s, full countdown.
    push_s = 1'b1; step(ST_SNOOZE, 2'd2, 4'd5, 4'b0000, 1'b0);
    step(ST_SNOOZE, 2'd2, 4'd5, 4'b0000, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      minute_tick = 1'b1; step(ST_SNOOZE, 2'd2, 4'(k), 4'b0000, 1'b0);
    end
    minute_tick = 1'b1; step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);

    // Snooze #2 by push_s.
    push_s = 1'b1; step(ST_SNOOZE, 2'd2, 4'd5, 4'b0000, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      minute_tick = 1'b1; step(ST_SNOOZE, 2'd2, 4'(k), 4'b0000, 1'b0);
    end
    minute_tick = 1'b1; step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);

    // Snooze #3 by ring timeout.
    minute_tick = 1'b1; step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);
    minute_tick = 1'b1; step(ST_SNOOZE, 2'd2, 4'd5, 4'b0000, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      minute_tick = 1'b1; step(ST_SNOOZE, 2'd2, 4'(k), 4'b0000, 1'b0);
    end
    minute_tick = 1'b1; step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);

    // Snoozes exhausted: push_s and timeout both leave it ringing.
    push_s = 1'b1;      step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);
    minute_tick = 1'b1; step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);
    minute_tick = 1'b1; step(ST_RING, 2'd2, 4'd0, 4'b0000, 1'b0);
    push_m = 1'b1; push_s = 1'b1; step(ST_GAME, 2'd2, 4'd0, 4'b0000, 1'b1);
    game_done = 1'b1;   step(ST_ARMED, 2'd2, 4'd0, 4'b0000, 1'b0);

    // Slot0 rings at 0900 and snoozes; slot2 rewritten to 0900 goes pending.
    cfg(2'd0, 16'h0900, 1'b1); step(ST_ARMED, 2'd2, 4'd0, 4'b0000, 1'b0);
    current = 16'h0900;        step(ST_ARMED, 2'd2, 4'd0, 4'b0001, 1'b0);
    step(ST_RING, 2'd0, 4'd0, 4'b0000, 1'b0);
    push_s = 1'b1;             step(ST_SNOOZE, 2'd0, 4'd5, 4'b0000, 1'b0);
    cfg(2'd2, 16'h0900, 1'b1); step(ST_SNOOZE, 2'd0, 4'd5, 4'b0000, 1'b0);
    step(ST_SNOOZE, 2'd0, 4'd5, 4'b0100, 1'b0);

    // Disable during SNOOZE clears everything; held matches stay silent on re-enable.
    enable = 1'b0; step(ST_IDLE, 2'd0, 4'd0, 4'b0000, 1'b0);
    step(ST_IDLE, 2'd0, 4'd0, 4'b0000, 1'b0);
    enable = 1'b1; step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);
    step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);

    // Rewriting a matching slot clears its history and re-latches.
    cfg(2'd0, 16'h0900, 1'b1); step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);
    step(ST_ARMED, 2'd0, 4'd0, 4'b0001, 1'b0);
    step(ST_RING, 2'd0, 4'd0, 4'b0000, 1'b0);
    push_m = 1'b1; step(ST_GAME, 2'd0, 4'd0, 4'b0000, 1'b1);

    // Asynchronous reset while game_start is high.
    reset = 1'b0;
    #1;
    check_reset("rst_game");
    @(negedge clk);
    check_reset("rst_hold");
    reset = 1'b1;
    step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);
    step(ST_ARMED, 2'd0, 4'd0, 4'b0000, 1'b0);

    repeat (2) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
